// File: rtl/controlador_paridade.sv
// rtl/controlador_paridade.sv - serial 5+1 bit frame receiver with parity check and saturating error counter
// Frame order on din: b1..b5 then bp; dado[4]=b1 ... dado[0]=b5.
module controlador_paridade #(
  parameter int PARIDADE = 0,
  parameter int WC       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din,
  input  logic          din_valid,
  input  logic          clr,
  output logic          busy,
  output logic          done,
  output logic          erro,
  output logic [4:0]    dado,
  output logic [WC-1:0] cont_erros
);

  typedef enum logic [1:0] {IDLE, RECEBE, FIM} estado_t;

  localparam logic          PAR_ALVO = (PARIDADE != 0);
  localparam logic [WC-1:0] CONT_MAX = '1;

  estado_t       estado_q, estado_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          erro_q, erro_d;
  logic [4:0]    dado_q, dado_d;
  logic [WC-1:0] cont_q, cont_d;

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    erro_d   = erro_q;
    dado_d   = dado_q;
    cont_d   = cont_q;

    case (estado_q)
      IDLE: begin
        if (start) begin
          estado_d = RECEBE;
          idx_d    = 3'd0;
          par_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RECEBE: begin
        if (din_valid) begin
          par_d = par_q ^ din;
          if (idx_q == 3'd5) begin
            // Only a complete frame reaches the visible result registers.
            estado_d = FIM;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            dado_d   = shift_q;
            erro_d   = ((par_q ^ din) != PAR_ALVO);
            if (erro_d && (cont_q != CONT_MAX)) begin
              cont_d = cont_q + 1'b1;
            end
          end else begin
            shift_d = {shift_q[3:0], din};
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      FIM: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
        busy_d   = 1'b0;
      end
    endcase

    if (clr) begin
      cont_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
      idx_q    <= 3'd0;
      shift_q  <= 5'd0;
      par_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
      dado_q   <= 5'd0;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      erro_q   <= erro_d;
      dado_q   <= dado_d;
      cont_q   <= cont_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign erro       = erro_q;
  assign dado       = dado_q;
  assign cont_erros = cont_q;

endmodule

// File: tb/tb_controlador_paridade.sv
// tb/tb_controlador_paridade.sv - scoreboard bench for controlador_paridade (even and odd instances)
module tb_controlador_paridade;

  logic clk = 1'b0;
  logic rst, start, din, din_valid, clr;
  logic       busy_p, done_p, erro_p, busy_i, done_i, erro_i;
  logic [4:0] dado_p, dado_i;
  logic [3:0] cont_p, cont_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] dado;
    logic       erro;
    int         cont;
  } exp_t;

  exp_t q_par[$];
  exp_t q_imp[$];
  exp_t ep, ei;
  int cnt_par = 0;
  int cnt_imp = 0;

  controlador_paridade #(.PARIDADE(0), .WC(4)) u_par (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid), .clr(clr),
    .busy(busy_p), .done(done_p), .erro(erro_p), .dado(dado_p), .cont_erros(cont_p)
  );

  controlador_paridade #(.PARIDADE(1), .WC(4)) u_imp (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid), .clr(clr),
    .busy(busy_i), .done(done_i), .erro(erro_i), .dado(dado_i), .cont_erros(cont_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: frame parity from plain XOR of all six bits, saturating count to 15.
  task automatic push_expected(input logic [4:0] d, input logic bp, input bit clr_fim);
    exp_t e;
    int ones;
    ones = $countones({d, bp});
    e.dado = d;
    e.erro = (ones % 2) != 0;
    if (clr_fim) cnt_par = 0;
    else if (e.erro && cnt_par < 15) cnt_par++;
    e.cont = cnt_par;
    q_par.push_back(e);
    e.erro = (ones % 2) != 1;
    if (clr_fim) cnt_imp = 0;
    else if (e.erro && cnt_imp < 15) cnt_imp++;
    e.cont = cnt_imp;
    q_imp.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && done_p) begin
      if (q_par.size() == 0) begin
        chk("unexpected_done_par", 32'(done_p), 32'd0);
      end else begin
        ep = q_par.pop_front();
        chk("dado_par", 32'(dado_p), 32'(ep.dado));
        chk("erro_par", 32'(erro_p), 32'(ep.erro));
        chk("cont_par", 32'(cont_p), 32'(ep.cont));
      end
    end
    if (!rst && done_i) begin
      if (q_imp.size() == 0) begin
        chk("unexpected_done_imp", 32'(done_i), 32'd0);
      end else begin
        ei = q_imp.pop_front();
        chk("dado_imp", 32'(dado_i), 32'(ei.dado));
        chk("erro_imp", 32'(erro_i), 32'(ei.erro));
        chk("cont_imp", 32'(cont_i), 32'(ei.cont));
      end
    end
  end

  task automatic send_frame(input logic [4:0] d, input logic bp, input logic [5:0] stall_mask,
                            input bit clr_fim, input bit start_mid, input bit start_fim);
    logic [5:0] bits;
    bits = {d, bp};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy_p), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (stall_mask[i]) begin
        din_valid = 1'b0;
        din = 1'($urandom);
        tick();
        chk("busy_stall", 32'(busy_p), 32'd1);
      end
      if (start_mid && i == 2) start = 1'b1;
      din = bits[5-i];
      din_valid = 1'b1;
      if (i == 5) begin
        clr = clr_fim;
        push_expected(d, bp, clr_fim);
      end
      tick();
      din_valid = 1'b0;
      clr = 1'b0;
      start = 1'b0;
      if (i < 5) chk("busy_mid", 32'(busy_p), 32'd1);
    end
    chk("done_latency", 32'({done_p, done_i}), 32'b11);
    chk("busy_in_fim", 32'(busy_p), 32'd0);
    start = start_fim;
    tick();
    start = 1'b0;
    chk("done_one_cycle", 32'({done_p, done_i}), 32'b00);
    chk("busy_after_fim", 32'({busy_p, busy_i}), 32'b00);
  endtask

  task automatic check_all_zero(input string nome);
    chk({nome, "_par"}, 32'({busy_p, done_p, erro_p, dado_p, cont_p}), 32'd0);
    chk({nome, "_imp"}, 32'({busy_i, done_i, erro_i, dado_i, cont_i}), 32'd0);
  endtask

  initial begin
    logic [4:0] d;
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; clr = 1'b0;
    tick();
    tick();
    check_all_zero("reset_state");
    rst = 1'b0;
    din_valid = 1'b1;
    din = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("idle_ignores_din", 32'(busy_p), 32'd0);

    send_frame(5'b10110, 1'b1, 6'b0, 0, 0, 0);
    send_frame(5'b10110, 1'b0, 6'b0, 0, 0, 0);
    send_frame(5'b00001, 1'b1, 6'b010101, 0, 0, 0);
    send_frame(5'b11001, 1'b0, 6'b0, 0, 1, 1);

    // Mid-frame reset after three accepted bits.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 1'($urandom);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    rst = 1'b1;
    #2;
    check_all_zero("async_reset");
    cnt_par = 0;
    cnt_imp = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = 1'($urandom);
      din_valid = 1'b1;
      tick();
      chk("no_start_busy", 32'(busy_p), 32'd0);
    end
    din_valid = 1'b0;
    tick();
    send_frame(5'b01101, 1'b0, 6'b0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      send_frame(5'($urandom), 1'($urandom), 6'($urandom) & 6'($urandom) & 6'($urandom),
                 ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
    end

    // Saturation of the even instance's counter, then clr racing an increment.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt_par = 0;
    cnt_imp = 0;
    chk("clr_idle", 32'(cont_p), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      d = 5'($urandom);
      send_frame(d, ~^d, 6'b0, 0, 0, 0);
      if (k >= 15) chk("cont_saturated", 32'(cont_p), 32'd15);
    end
    d = 5'($urandom);
    send_frame(d, ~^d, 6'b0, 1, 0, 0);
    chk("clr_wins", 32'(cont_p), 32'd0);

    tick();
    tick();
    chk("queue_par_empty", 32'(q_par.size()), 32'd0);
    chk("queue_imp_empty", 32'(q_imp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
